// File: rtl/obstacle_avoid_fsm.sv
// ---------------------------------------------------------------------------
// obstacle_avoid_fsm
// Autonomous-drive obstacle avoidance controller. Samples the ultrasonic
// distance once per SAMPLE_CYC clocks, counts consecutive "near" samples and,
// while driving forward, runs a fixed BRAKE -> REVERSE -> TURN manoeuvre once
// NEAR_CNT consecutive near samples have been seen.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-low reset
//   en         in   1   autonomous drive enable (drop -> IDLE next edge)
//   dis        in  20   measured distance, 0.01 cm units, 0 = no echo yet
//   state      out  3   current state code (IDLE0 FWD1 BRAKE2 REV3 TURN4)
//   left_fwd   out  1   left motor forward
//   left_rev   out  1   left motor reverse
//   right_fwd  out  1   right motor forward
//   right_rev  out  1   right motor reverse
//   avoid_cnt  out  8   manoeuvres started, saturating at 255
// ---------------------------------------------------------------------------
module obstacle_avoid_fsm #(
    parameter int unsigned SAMPLE_CYC = 32'd10_000_000,
    parameter logic [19:0] THRESH     = 20'd4000,
    parameter int unsigned NEAR_CNT   = 32'd3,
    parameter int unsigned BRAKE_CYC  = 32'd5_000_000,
    parameter int unsigned REV_CYC    = 32'd50_000_000,
    parameter int unsigned TURN_CYC   = 32'd40_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] dis,
    output logic [2:0]  state,
    output logic        left_fwd,
    output logic        left_rev,
    output logic        right_fwd,
    output logic        right_rev,
    output logic [7:0]  avoid_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_BRAKE = 3'd2,
        ST_REV   = 3'd3,
        ST_TURN  = 3'd4
    } state_e;

    // Terminal values of the 32-bit timers (last cycle of each period).
    localparam logic [31:0] SAMPLE_LAST = 32'(SAMPLE_CYC - 32'd1);
    localparam logic [31:0] BRAKE_LAST  = 32'(BRAKE_CYC - 32'd1);
    localparam logic [31:0] REV_LAST    = 32'(REV_CYC - 32'd1);
    localparam logic [31:0] TURN_LAST   = 32'(TURN_CYC - 32'd1);
    localparam logic [31:0] NEAR_MAX    = 32'(NEAR_CNT);

    // Motor vector order: {left_fwd, left_rev, right_fwd, right_rev}.
    // Each pattern keeps fwd and rev exclusive per side by construction.
    function automatic logic [3:0] motor_decode(input state_e s);
        logic [3:0] m;
        case (s)
            ST_FWD:  m = 4'b1010;
            ST_REV:  m = 4'b0101;
            ST_TURN: m = 4'b1001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] samp_q, samp_d;
    logic [31:0] near_q, near_d;
    logic [31:0] dwell_q, dwell_d;
    logic [7:0]  avoid_q, avoid_d;
    logic [3:0]  motor_q, motor_d;
    logic        samp_tick_s;
    logic        dis_near_s;

    // Next-state logic for the sample timer, near counter, FSM and outputs.
    always_comb begin
        samp_tick_s = (samp_q == SAMPLE_LAST);
        samp_d      = samp_tick_s ? 32'd0 : (samp_q + 32'd1);
        // No echo (dis == 0) is treated as far.
        dis_near_s  = (dis != 20'd0) && (dis < THRESH);

        near_d = near_q;
        if (samp_tick_s) begin
            if (dis_near_s) begin
                if (near_q < NEAR_MAX) begin
                    near_d = near_q + 32'd1;
                end else begin
                    near_d = NEAR_MAX;
                end
            end else begin
                near_d = 32'd0;
            end
        end else begin
            near_d = near_q;
        end

        state_d = state_q;
        avoid_d = avoid_q;
        if (!en) begin
            // Enable drop overrides every other transition.
            state_d = ST_IDLE;
            near_d  = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FWD;
                end
                ST_FWD: begin
                    if (near_q == NEAR_MAX) begin
                        state_d = ST_BRAKE;
                        avoid_d = (avoid_q == 8'hFF) ? avoid_q : (avoid_q + 8'd1);
                    end else begin
                        state_d = ST_FWD;
                    end
                end
                ST_BRAKE: begin
                    if (dwell_q == BRAKE_LAST) begin
                        state_d = ST_REV;
                    end else begin
                        state_d = ST_BRAKE;
                    end
                end
                ST_REV: begin
                    if (dwell_q == REV_LAST) begin
                        state_d = ST_TURN;
                    end else begin
                        state_d = ST_REV;
                    end
                end
                ST_TURN: begin
                    if (dwell_q == TURN_LAST) begin
                        // Re-arm obstacle detection for the new heading.
                        state_d = ST_FWD;
                        near_d  = 32'd0;
                    end else begin
                        state_d = ST_TURN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Dwell timer restarts on every state entry and only runs in timed states.
        if (state_d != state_q) begin
            dwell_d = 32'd0;
        end else if ((state_q == ST_BRAKE) || (state_q == ST_REV) || (state_q == ST_TURN)) begin
            dwell_d = dwell_q + 32'd1;
        end else begin
            dwell_d = 32'd0;
        end

        // Decoding the next state keeps motors in step with the state register.
        motor_d = motor_decode(state_d);
    end

    // State, timers, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            samp_q  <= 32'd0;
            near_q  <= 32'd0;
            dwell_q <= 32'd0;
            avoid_q <= 8'd0;
            motor_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            near_q  <= near_d;
            dwell_q <= dwell_d;
            avoid_q <= avoid_d;
            motor_q <= motor_d;
        end
    end

    assign state     = state_q;
    assign left_fwd  = motor_q[3];
    assign left_rev  = motor_q[2];
    assign right_fwd = motor_q[1];
    assign right_rev = motor_q[0];
    assign avoid_cnt = avoid_q;

endmodule

// File: tb/tb_obstacle_avoid_fsm.sv
// ---------------------------------------------------------------------------
// Self-checking bench for obstacle_avoid_fsm with small timing parameters.
// A behavioural model (sample phase, near streak, remaining dwell) runs
// alongside the DUT; directed table vectors and corner sequences add fixed
// expectations on top.
// ---------------------------------------------------------------------------
module tb_obstacle_avoid_fsm;

    localparam int SC = 10;
    localparam int NC = 3;
    localparam int TH = 4000;
    localparam int BC = 4;
    localparam int RC = 8;
    localparam int TC = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [19:0] dis;
    logic [2:0]  state;
    logic        left_fwd, left_rev, right_fwd, right_rev;
    logic [7:0]  avoid_cnt;

    always #5 clk = ~clk;

    obstacle_avoid_fsm #(
        .SAMPLE_CYC(32'd10),
        .THRESH    (20'd4000),
        .NEAR_CNT  (32'd3),
        .BRAKE_CYC (32'd4),
        .REV_CYC   (32'd8),
        .TURN_CYC  (32'd6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dis      (dis),
        .state    (state),
        .left_fwd (left_fwd),
        .left_rev (left_rev),
        .right_fwd(right_fwd),
        .right_rev(right_rev),
        .avoid_cnt(avoid_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: 0 IDLE, 1 FWD, 2 BRAKE, 3 REV, 4 TURN.
    int m_phase, m_near, m_state, m_left, m_avoid, m_starts;
    logic [3:0] mot_tab [5] = '{4'b0000, 4'b1010, 4'b0000, 4'b0101, 4'b1001};

    typedef struct {
        logic       en;
        int         dis;
        int         cycles;
        int         exp_state;
        logic [3:0] exp_mot;
        int         exp_avoid;
    } vec_t;
    vec_t vt [14];

    function automatic logic [3:0] dut_mot();
        return {left_fwd, left_rev, right_fwd, right_rev};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_near = 0; m_state = 0; m_left = 0; m_avoid = 0; m_starts = 0;
    endtask

    task automatic model_step();
        int old_near;
        bit tick;
        tick     = (m_phase == SC - 1);
        m_phase  = tick ? 0 : m_phase + 1;
        old_near = m_near;
        if (tick) begin
            if (int'(dis) > 0 && int'(dis) < TH) m_near = (m_near < NC) ? m_near + 1 : NC;
            else m_near = 0;
        end
        if (!en) begin
            m_state = 0;
            m_near  = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (old_near == NC) begin
                       m_state = 2;
                       m_left  = BC;
                       m_starts++;
                       if (m_avoid < 255) m_avoid++;
                   end
                2, 3, 4: begin
                    if (m_left == 1) begin
                        if (m_state == 4) begin
                            m_state = 1;
                            m_near  = 0;
                        end else if (m_state == 2) begin
                            m_state = 3;
                            m_left  = RC;
                        end else begin
                            m_state = 4;
                            m_left  = TC;
                        end
                    end else begin
                        m_left--;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: advance model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("model_state", int'(state), m_state);
        check("model_motor", int'(dut_mot()), int'(mot_tab[m_state]));
        check("model_avoid", int'(avoid_cnt), m_avoid);
        check("fwd_rev_excl", int'((left_fwd & left_rev) | (right_fwd & right_rev)), 0);
    endtask

    task automatic wait_model_state(input int target, input string name);
        int n;
        n = 0;
        while (m_state != target && n < 400) begin
            step();
            n++;
        end
        check(name, m_state, target);
    endtask

    initial begin
        vt[0]  = '{1'b0, 10000,  2, 0, 4'b0000, 0};
        vt[1]  = '{1'b1, 10000,  1, 1, 4'b1010, 0};
        vt[2]  = '{1'b1, 10000, 20, 1, 4'b1010, 0};
        vt[3]  = '{1'b1,  3000,  7, 1, 4'b1010, 0};
        vt[4]  = '{1'b1,  3000, 10, 1, 4'b1010, 0};
        vt[5]  = '{1'b1,  3000, 10, 1, 4'b1010, 0};
        vt[6]  = '{1'b1,  3000,  1, 2, 4'b0000, 1};
        vt[7]  = '{1'b1,  3000,  3, 2, 4'b0000, 1};
        vt[8]  = '{1'b1,  3000,  1, 3, 4'b0101, 1};
        vt[9]  = '{1'b1,  3000,  7, 3, 4'b0101, 1};
        vt[10] = '{1'b1,  3000,  1, 4, 4'b1001, 1};
        vt[11] = '{1'b1,  3000,  5, 4, 4'b1001, 1};
        vt[12] = '{1'b1, 10000,  1, 1, 4'b1010, 1};
        vt[13] = '{1'b1, 10000, 30, 1, 4'b1010, 1};

        // Reset is asynchronous: outputs must be clear before any clock edge.
        rst = 1'b0; en = 1'b0; dis = 20'd10000;
        model_reset();
        #1;
        check("reset_state", int'(state), 0);
        check("reset_motor", int'(dut_mot()), 0);
        check("reset_avoid", int'(avoid_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed table: drive-off, one full manoeuvre, return to FWD.
        for (int i = 0; i < 14; i++) begin
            en  = vt[i].en;
            dis = 20'(vt[i].dis);
            for (int c = 0; c < vt[i].cycles; c++) step();
            check($sformatf("vec%0d_state", i), int'(state), vt[i].exp_state);
            check($sformatf("vec%0d_motor", i), int'(dut_mot()), int'(vt[i].exp_mot));
            check($sformatf("vec%0d_avoid", i), int'(avoid_cnt), vt[i].exp_avoid);
        end

        // Alternating near/far ticks never build a streak.
        for (int w = 0; w < 6; w++) begin
            dis = (w % 2 == 0) ? 20'd3000 : 20'd10000;
            for (int c = 0; c < SC; c++) step();
            check("alt_stays_fwd", int'(state), 1);
        end
        // No echo counts as far.
        dis = 20'd0;
        for (int c = 0; c < 5 * SC; c++) step();
        check("zero_stays_fwd", int'(state), 1);

        // Enable drop during REV.
        dis = 20'd3000;
        wait_model_state(3, "reach_rev");
        en = 1'b0;
        step();
        check("endrop_state", int'(state), 0);
        check("endrop_motor", int'(dut_mot()), 0);
        en = 1'b1; dis = 20'd10000;
        step();
        check("reenable_fwd", int'(state), 1);
        dis = 20'd3000;
        for (int c = 0; c < 15; c++) step();
        check("near_cleared_fwd", int'(state), 1);

        // Asynchronous reset pulse between edges during TURN.
        wait_model_state(4, "reach_turn");
        step();
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_motor", int'(dut_mot()), 0);
        check("async_rst_avoid", int'(avoid_cnt), 0);
        model_reset();
        #2 rst = 1'b1;
        dis = 20'd10000;
        step();
        check("post_rst_fwd", int'(state), 1);

        // Saturation: 260 forced manoeuvres.
        begin
            int n;
            n = 0;
            dis = 20'd3000;
            while (m_starts < 260 && n < 20000) begin
                step();
                n++;
            end
            check("sat_manoeuvres_done", m_starts, 260);
            check("sat_avoid_255", int'(avoid_cnt), 255);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 99) < 98) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: dis = 20'd0;
                    1: dis = 20'd3999;
                    2: dis = 20'd4000;
                    3: dis = 20'd4001;
                    4: dis = 20'($urandom_range(1, 3999));
                    default: dis = 20'($urandom_range(4001, 100000));
                endcase
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obstacle_avoid_fsm.md
OBSTACLE_AVOID_FSM -- requirements
Module: obstacle_avoid_fsm

Interface
REQ-001 SHALL have parameter SAMPLE_CYC, default 10_000_000, clk cycles per distance sample (10 Hz at 100 MHz, matches ranging trigger period).
REQ-002 SHALL have parameter THRESH, default 20'd4000, near threshold in dis units (0.01 cm; 40.00 cm).
REQ-003 SHALL have parameter NEAR_CNT, default 3, consecutive near samples needed to start avoidance.
REQ-004 SHALL have parameter BRAKE_CYC, default 5_000_000, BRAKE dwell in clk cycles.
REQ-005 SHALL have parameter REV_CYC, default 50_000_000, REVERSE dwell in clk cycles.
REQ-006 SHALL have parameter TURN_CYC, default 40_000_000, TURN dwell in clk cycles.
REQ-007 SHALL have port clk  input  1  system clock (100 MHz).
REQ-008 SHALL have port rst  input  1  reset; one clock, rst asynchronous and active-low (asserted when 0).
REQ-009 SHALL have port en  input  1  autonomous drive enable.
REQ-010 SHALL have port dis  input  20  measured distance from ultrasonic ranging stage, 0.01 cm units; 0 = no valid echo yet.
REQ-011 SHALL have port state  output  3  current FSM state code.
REQ-012 SHALL have ports left_fwd, left_rev, right_fwd, right_rev  output  1 each  motor direction commands.
REQ-013 SHALL have port avoid_cnt  output  8  number of avoidance manoeuvres started, saturating.

Function
REQ-014 Sample timer: free-running 0..SAMPLE_CYC-1, wraps to 0; sample tick asserted for the one cycle at SAMPLE_CYC-1.
REQ-015 On tick, if 0 < dis < THRESH: near counter increments, saturates at NEAR_CNT; otherwise near counter cleared to 0.
REQ-016 dis == 0 SHALL count as far (clears near counter).
REQ-017 States/codes: IDLE=0, FWD=1, BRAKE=2, REV=3, TURN=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-018 IDLE -> FWD on the first clk edge with en=1.
REQ-019 FWD -> BRAKE on the edge where near counter == NEAR_CNT; avoid_cnt increments on this transition, holds at 255.
REQ-020 Dwell timer cleared on every state entry; BRAKE/REV/TURN each last exactly BRAKE_CYC/REV_CYC/TURN_CYC cycles, then BRAKE->REV, REV->TURN, TURN->FWD.
REQ-021 Near counter SHALL be cleared on the TURN->FWD edge; sampling continues in all states, but only FWD acts on it.
REQ-022 en=0 in any state -> IDLE on the next edge, dwell timer and near counter cleared; en has priority over all other transitions.
REQ-023 Motor outputs decoded from the state register only: IDLE/BRAKE all 0; FWD left_fwd=right_fwd=1; REV left_rev=right_rev=1; TURN left_fwd=1, right_rev=1.
REQ-024 For each side, fwd and rev SHALL never both be 1 in any cycle.
REQ-025 state output equals the state register; motor outputs change in the same cycle as state.
REQ-026 Timers SHALL be sized for the largest parameter (32-bit); there SHALL be no overflow at the default values.

Reset
REQ-027 While rst=0: state=IDLE(0), all motor outputs 0, avoid_cnt=0, near counter 0, sample and dwell timers 0; takes effect immediately, without a clock edge.
REQ-028 Reset asserted mid-manoeuvre SHALL abort the manoeuvre; after release, IDLE -> FWD needs en=1 on a clk edge.

Verification (SAMPLE_CYC=10, NEAR_CNT=3, THRESH=4000, BRAKE_CYC=4, REV_CYC=8, TURN_CYC=6)
REQ-029 Release rst, en=1, dis=10000 -> state 1 next edge, left_fwd=right_fwd=1, stays FWD indefinitely, avoid_cnt=0.
REQ-030 In FWD set dis=3000 -> BRAKE after 3rd tick; BRAKE 4 cycles, REV 8, TURN 6, then FWD; avoid_cnt=1; outputs match REQ-023 throughout.
REQ-031 dis alternates 3000/10000 on successive ticks -> never leaves FWD; dis=0 for 5 ticks -> never leaves FWD.
REQ-032 en dropped during REV -> IDLE next edge, outputs all 0; en=1 again with dis=10000 -> FWD, near counter 0.
REQ-033 rst pulsed low between clk edges during TURN -> outputs 0 and state 0 immediately; avoid_cnt=0.
REQ-034 260 forced manoeuvres -> avoid_cnt holds 255; checker confirms fwd&rev never both 1 on either side.
